// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline barriers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Holds the default datapath widths, the write-back entry record used by
// the storage slots of the MEM/WB barrier, and the skid depth.
package pipeline_pkg;

  localparam int PIPE_XLEN      = 32;
  localparam int PIPE_REG_IDX_W = 5;

  // Occupancy at which a two-entry barrier stops accepting.
  localparam logic [1:0] SKID_DEPTH = 2'd2;

  // One write-back entry at the default widths.
  // Barriers built with other widths declare a local record
  // with the same field layout.
  typedef struct packed {
    logic [PIPE_XLEN-1:0]      memoryData;
    logic [PIPE_XLEN-1:0]      executionData;
    logic [PIPE_REG_IDX_W-1:0] writeRegisterIndex;
    logic                      memToReg;
    logic                      regWrite;
  } wb_entry_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single-entry storage slot: loads d when load is high, cleared
// asynchronously by resetN. Used as both head and skid slot of a barrier.
// Ports: clk, resetN (async active-low), load, d[W], q[W].
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_barrier.sv
// MEM->WB pipeline barrier with valid/ready handshake and a 2-entry skid
// buffer (head + skid slot, FIFO order). Every wb* output is taken from the
// head slot or the occupancy register, so no input reaches an output
// combinationally. Supports synchronous flush, x0 write suppression and a
// forwarding tap for the hazard unit.
// Ports:
//   clk, resetN (async active-low), flush
//   MEM side : memValid, memReady, memMemoryData, memExecutionData,
//              memWriteRegisterIndex, memMemToReg, memRegWrite
//   WB side  : wbValid, wbReady, wbMemoryData, wbExecutionData,
//              wbWriteRegisterIndex, wbMemToReg, wbRegWrite, wbWriteData
//   forward  : fwdValid, fwdIndex, fwdData
//   status   : count (0..2)
module mem_wb_skid_barrier
  import pipeline_pkg::*;
#(
  parameter int XLEN              = PIPE_XLEN,
  parameter int REG_IDX_W         = PIPE_REG_IDX_W,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 flush,
  input  logic                 memValid,
  output logic                 memReady,
  input  logic [XLEN-1:0]      memMemoryData,
  input  logic [XLEN-1:0]      memExecutionData,
  input  logic [REG_IDX_W-1:0] memWriteRegisterIndex,
  input  logic                 memMemToReg,
  input  logic                 memRegWrite,
  output logic                 wbValid,
  input  logic                 wbReady,
  output logic [XLEN-1:0]      wbMemoryData,
  output logic [XLEN-1:0]      wbExecutionData,
  output logic [REG_IDX_W-1:0] wbWriteRegisterIndex,
  output logic                 wbMemToReg,
  output logic                 wbRegWrite,
  output logic [XLEN-1:0]      wbWriteData,
  output logic                 fwdValid,
  output logic [REG_IDX_W-1:0] fwdIndex,
  output logic [XLEN-1:0]      fwdData,
  output logic [1:0]           count
);

  typedef struct packed {
    logic [XLEN-1:0]      memoryData;
    logic [XLEN-1:0]      executionData;
    logic [REG_IDX_W-1:0] writeRegisterIndex;
    logic                 memToReg;
    logic                 regWrite;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t     in_entry;
  entry_t     head_q;
  entry_t     skid_q;
  entry_t     head_d;
  logic       head_load;
  logic       skid_load;
  logic       accept;
  logic       pop;
  logic       idx_ok;
  logic [1:0] count_reg;
  logic [1:0] count_next;

  assign in_entry = '{
    memoryData:         memMemoryData,
    executionData:      memExecutionData,
    writeRegisterIndex: memWriteRegisterIndex,
    memToReg:           memMemToReg,
    regWrite:           memRegWrite
  };

  assign memReady = (count_reg < SKID_DEPTH);
  assign wbValid  = (count_reg != 2'd0);
  assign accept   = memValid & memReady;
  assign pop      = wbValid & wbReady;

  // Flush wins over accept and pop; no slot is loaded, so the head data
  // outputs keep their last value while wbValid drops.
  always_comb begin
    count_next = count_reg;
    head_load  = 1'b0;
    skid_load  = 1'b0;
    head_d     = in_entry;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (accept) begin
            head_load  = 1'b1;
            count_next = 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            // Consumed head is replaced by the new entry in place.
            head_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            count_next = 2'd2;
          end else if (pop) begin
            count_next = 2'd0;
          end
        end
        2'd2: begin
          // memReady is low here, so only a pop can happen.
          if (pop) begin
            head_load  = 1'b1;
            head_d     = skid_q;
            count_next = 2'd1;
          end
        end
        default: count_next = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  pipe_skid_slot #(.W(ENTRY_W)) u_head (
    .clk    (clk),
    .resetN (resetN),
    .load   (head_load),
    .d      (head_d),
    .q      (head_q)
  );

  pipe_skid_slot #(.W(ENTRY_W)) u_skid (
    .clk    (clk),
    .resetN (resetN),
    .load   (skid_load),
    .d      (in_entry),
    .q      (skid_q)
  );

  assign idx_ok = ZERO_REG_SUPPRESS ? (head_q.writeRegisterIndex != '0) : 1'b1;

  assign wbMemoryData         = head_q.memoryData;
  assign wbExecutionData      = head_q.executionData;
  assign wbWriteRegisterIndex = head_q.writeRegisterIndex;
  assign wbMemToReg           = head_q.memToReg;
  assign wbRegWrite           = head_q.regWrite & idx_ok & wbValid;
  assign wbWriteData          = head_q.memToReg ? head_q.memoryData : head_q.executionData;

  assign fwdValid = wbRegWrite;
  assign fwdIndex = head_q.writeRegisterIndex;
  assign fwdData  = wbWriteData;
  assign count    = count_reg;

endmodule

// File: tb/tb_mem_wb_skid_barrier.sv
// Self-checking bench for mem_wb_skid_barrier. A queue-based FIFO model of
// the barrier predicts every output; a second instance with x0 suppression
// disabled shares all inputs and is used for the wbRegWrite comparison.
module tb_mem_wb_skid_barrier;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        flush = 1'b0;
  logic        memValid = 1'b0;
  logic [31:0] memMemoryData = '0;
  logic [31:0] memExecutionData = '0;
  logic [4:0]  memWriteRegisterIndex = '0;
  logic        memMemToReg = 1'b0;
  logic        memRegWrite = 1'b0;
  logic        wbReady = 1'b0;

  logic        memReady, wbValid, wbMemToReg, wbRegWrite, fwdValid;
  logic [31:0] wbMemoryData, wbExecutionData, wbWriteData, fwdData;
  logic [4:0]  wbWriteRegisterIndex, fwdIndex;
  logic [1:0]  count;

  logic        nz_memReady, nz_wbValid, nz_wbMemToReg, nz_wbRegWrite, nz_fwdValid;
  logic [31:0] nz_wbMemoryData, nz_wbExecutionData, nz_wbWriteData, nz_fwdData;
  logic [4:0]  nz_wbWriteRegisterIndex, nz_fwdIndex;
  logic [1:0]  nz_count;

  always #5 clk = ~clk;

  mem_wb_skid_barrier dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .memValid(memValid), .memReady(memReady),
    .memMemoryData(memMemoryData), .memExecutionData(memExecutionData),
    .memWriteRegisterIndex(memWriteRegisterIndex),
    .memMemToReg(memMemToReg), .memRegWrite(memRegWrite),
    .wbValid(wbValid), .wbReady(wbReady),
    .wbMemoryData(wbMemoryData), .wbExecutionData(wbExecutionData),
    .wbWriteRegisterIndex(wbWriteRegisterIndex),
    .wbMemToReg(wbMemToReg), .wbRegWrite(wbRegWrite), .wbWriteData(wbWriteData),
    .fwdValid(fwdValid), .fwdIndex(fwdIndex), .fwdData(fwdData), .count(count)
  );

  mem_wb_skid_barrier #(.ZERO_REG_SUPPRESS(1'b0)) dut_nz (
    .clk(clk), .resetN(resetN), .flush(flush),
    .memValid(memValid), .memReady(nz_memReady),
    .memMemoryData(memMemoryData), .memExecutionData(memExecutionData),
    .memWriteRegisterIndex(memWriteRegisterIndex),
    .memMemToReg(memMemToReg), .memRegWrite(memRegWrite),
    .wbValid(nz_wbValid), .wbReady(wbReady),
    .wbMemoryData(nz_wbMemoryData), .wbExecutionData(nz_wbExecutionData),
    .wbWriteRegisterIndex(nz_wbWriteRegisterIndex),
    .wbMemToReg(nz_wbMemToReg), .wbRegWrite(nz_wbRegWrite), .wbWriteData(nz_wbWriteData),
    .fwdValid(nz_fwdValid), .fwdIndex(nz_fwdIndex), .fwdData(nz_fwdData), .count(nz_count)
  );

  typedef struct {
    logic [31:0] md;
    logic [31:0] ed;
    logic [4:0]  idx;
    logic        m2r;
    logic        rw;
  } ent_t;

  ent_t q[$];
  ent_t last;
  ent_t idle;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  function automatic ent_t mk(logic [31:0] md, logic [31:0] ed, logic [4:0] idx,
                              logic m2r, logic rw);
    ent_t e;
    e.md = md; e.ed = ed; e.idx = idx; e.m2r = m2r; e.rw = rw;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's head (or the last head when empty).
  task automatic check_outputs();
    logic        v;
    ent_t        h;
    logic [31:0] wd;
    v  = (q.size() > 0);
    h  = v ? q[0] : last;
    wd = h.m2r ? h.md : h.ed;
    chk("count", 32'(count), 32'(q.size()));
    chk("memReady", 32'(memReady), 32'(q.size() < 2));
    chk("wbValid", 32'(wbValid), 32'(v));
    chk("wbMemoryData", wbMemoryData, h.md);
    chk("wbExecutionData", wbExecutionData, h.ed);
    chk("wbWriteRegisterIndex", 32'(wbWriteRegisterIndex), 32'(h.idx));
    chk("wbMemToReg", 32'(wbMemToReg), 32'(h.m2r));
    chk("wbWriteData", wbWriteData, wd);
    chk("wbRegWrite", 32'(wbRegWrite), 32'(v && h.rw && (h.idx != 5'd0)));
    chk("fwdValid", 32'(fwdValid), 32'(v && h.rw && (h.idx != 5'd0)));
    chk("fwdIndex", 32'(fwdIndex), 32'(h.idx));
    chk("fwdData", fwdData, wd);
    chk("nz_wbRegWrite", 32'(nz_wbRegWrite), 32'(v && h.rw));
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(ent_t e, logic v, logic rdy, logic fl);
    logic acc, pp;
    memValid = v; wbReady = rdy; flush = fl;
    memMemoryData = e.md; memExecutionData = e.ed;
    memWriteRegisterIndex = e.idx; memMemToReg = e.m2r; memRegWrite = e.rw;
    @(posedge clk);
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && rdy;
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    #1;
    check_outputs();
    txn++;
    $display("txn %0d: valid=%0b ready=%0b flush=%0b count=%0d wbValid=%0b wbWriteData=%h",
             txn, v, rdy, fl, count, wbValid, wbWriteData);
  endtask

  initial begin
    idle = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    last = idle;

    // Reset state
    #12;
    check_outputs();
    @(negedge clk);
    resetN = 1'b1;

    // Single accept, latency 1, then empty
    step(mk(32'h0, 32'h12345678, 5'd7, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    chk("t1_wbWriteData", wbWriteData, 32'h12345678);
    chk("t1_fwdIndex", 32'(fwdIndex), 32'd7);
    step(idle, 1'b0, 1'b1, 1'b0);
    chk("t1_wbValid_after_pop", 32'(wbValid), 32'd0);

    // Backpressure: fill both slots, then drain in order
    step(mk(32'h0, 32'hA, 5'd3, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    step(mk(32'hB, 32'h0, 5'd4, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0);
    chk("t2_count_full", 32'(count), 32'd2);
    chk("t2_memReady_full", 32'(memReady), 32'd0);
    chk("t2_head_A", wbWriteData, 32'hA);
    step(idle, 1'b0, 1'b1, 1'b0);
    chk("t2_head_B", wbWriteData, 32'hB);
    chk("t2_memReady_back", 32'(memReady), 32'd1);
    step(idle, 1'b0, 1'b1, 1'b0);

    // Steady stream 1..10 with no gaps
    for (int i = 1; i <= 10; i++) begin
      step(mk(32'h0, 32'(i), 5'd1, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
      chk("t3_stream_data", wbWriteData, 32'(i));
      chk("t3_stream_count", 32'(count), 32'd1);
    end
    step(idle, 1'b0, 1'b1, 1'b0);

    // Flush at count=2 with an offer in the same cycle
    step(mk(32'h0, 32'h11, 5'd2, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    step(mk(32'h0, 32'h22, 5'd2, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    step(mk(32'h0, 32'hDEAD, 5'd2, 1'b0, 1'b1), 1'b1, 1'b1, 1'b1);
    chk("t4_count_flushed", 32'(count), 32'd0);
    chk("t4_wbValid_flushed", 32'(wbValid), 32'd0);
    step(idle, 1'b0, 1'b1, 1'b0);

    // x0 suppression
    step(mk(32'h0, 32'h55, 5'd0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    chk("t5_wbValid", 32'(wbValid), 32'd1);
    chk("t5_wbRegWrite_x0", 32'(wbRegWrite), 32'd0);
    chk("t5_fwdValid_x0", 32'(fwdValid), 32'd0);
    chk("t5_nz_wbRegWrite_x0", 32'(nz_wbRegWrite), 32'd1);
    step(idle, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step(mk($urandom, $urandom, 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-cycle at count=2
    step(idle, 1'b0, 1'b1, 1'b1);
    step(mk(32'h0, 32'h77, 5'd5, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    step(mk(32'h88, 32'h0, 5'd6, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0);
    chk("t6_count_before_reset", 32'(count), 32'd2);
    #2;
    resetN = 1'b0;
    #1;
    q.delete();
    last = idle;
    check_outputs();
    @(negedge clk);
    resetN = 1'b1;
    step(idle, 1'b0, 1'b1, 1'b0);
    chk("t6_count_after_release", 32'(count), 32'd0);
    chk("t6_memReady_after_release", 32'(memReady), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
